// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - shared game-control types: state encoding, tick periods, level thresholds
package sc_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sc_state_e;

  // Tick periods in 50 MHz clock cycles
  localparam int unsigned PERIOD_035S = 17_500_000;
  localparam int unsigned PERIOD_030S = 15_000_000;
  localparam int unsigned PERIOD_025S = 12_500_000;

  localparam int unsigned LEVEL_TH_0 = 10;
  localparam int unsigned LEVEL_TH_1 = 17;
  localparam int unsigned LEVEL_TH_2 = 32;
  localparam int unsigned LEVEL_TH_3 = 39;
  localparam int unsigned LEVEL_TH_4 = 59;

  // Period the control FSM should program for a given level
  function automatic int unsigned period_for_level(input int unsigned level);
    if (level < LEVEL_TH_0) begin
      return PERIOD_035S;
    end else if (level < LEVEL_TH_2) begin
      return PERIOD_030S;
    end else begin
      return PERIOD_025S;
    end
  endfunction

endpackage

// File: rtl/sc_levelticker_downcounter.sv
// rtl/sc_levelticker_downcounter.sv - loadable down-counter with expiry pulse and zero-to-one period clamp
module sc_levelticker_downcounter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] period_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_val;

  assign reload_val = (period_i == '0) ? WIDTH'(1) : period_i;

  // <=1 rather than ==1 so a stray zero count can never wrap to all-ones
  assign expire_o = en_i && (count_q <= WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i || expire_o) begin
      count_q <= reload_val;
    end else if (en_i) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_levelticker.sv
// rtl/sc_levelticker.sv - periodic tick and saturating level counter; optional pause via SC_LEVELTICKER_PAUSE_EN
module sc_levelticker
  import sc_game_pkg::*;
#(
  parameter int PERIOD_WIDTH    = 32,
  parameter int LEVEL_WIDTH     = 8,
  parameter int TICKS_PER_LEVEL = 8,
  parameter int MAX_LEVEL       = 59
) (
  input  logic                    SC_LEVELTICKER_CLOCK_50,
  input  logic                    SC_LEVELTICKER_RESET_InHigh,
  input  logic                    SC_LEVELTICKER_START_InLow,
  input  logic [PERIOD_WIDTH-1:0] SC_LEVELTICKER_PERIOD_In,
`ifdef SC_LEVELTICKER_PAUSE_EN
  input  logic                    SC_LEVELTICKER_PAUSE_InLow,
`endif
  output logic                    SC_LEVELTICKER_TICK_Out,
  output logic                    SC_LEVELTICKER_LEVELUP_Out,
  output logic [LEVEL_WIDTH-1:0]  SC_LEVELTICKER_LEVEL_Out,
  output logic                    SC_LEVELTICKER_RUNNING_Out,
  output logic                    SC_LEVELTICKER_DONE_Out
);

  localparam int TW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
  localparam logic [TW-1:0]          TCNT_LAST = TW'(TICKS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] MAX_L     = LEVEL_WIDTH'(MAX_LEVEL);

  sc_state_e               state_q, state_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic                    tick_q;
  logic                    levelup_q, levelup_d;
  logic                    load;
  logic                    cnt_en;
  logic                    expire;

  sc_levelticker_downcounter #(
    .WIDTH(PERIOD_WIDTH)
  ) u_downcounter (
    .clk_i    (SC_LEVELTICKER_CLOCK_50),
    .rst_i    (SC_LEVELTICKER_RESET_InHigh),
    .load_i   (load),
    .en_i     (cnt_en),
    .period_i (SC_LEVELTICKER_PERIOD_In),
    .expire_o (expire)
  );

  // Counting stops once LEVEL sits at MAX_LEVEL, so the final RUN cycle
  // before DONE issues no further tick.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    cnt_en    = 1'b0;
    tcnt_d    = tcnt_q;
    level_d   = level_q;
    levelup_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!SC_LEVELTICKER_START_InLow) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (level_q == MAX_L) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
`ifdef SC_LEVELTICKER_PAUSE_EN
          if (!SC_LEVELTICKER_PAUSE_InLow) begin
            state_d = ST_PAUSE;
          end
`endif
        end
      end
`ifdef SC_LEVELTICKER_PAUSE_EN
      ST_PAUSE: begin
        if (SC_LEVELTICKER_PAUSE_InLow) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (expire) begin
      if (tcnt_q == TCNT_LAST) begin
        tcnt_d = '0;
        if (level_q != MAX_L) begin
          level_d   = level_q + LEVEL_WIDTH'(1);
          levelup_d = 1'b1;
        end
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge SC_LEVELTICKER_CLOCK_50) begin
    if (SC_LEVELTICKER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      tcnt_q    <= '0;
      level_q   <= '0;
      tick_q    <= 1'b0;
      levelup_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      level_q   <= level_d;
      tick_q    <= expire;
      levelup_q <= levelup_d;
    end
  end

  assign SC_LEVELTICKER_TICK_Out    = tick_q;
  assign SC_LEVELTICKER_LEVELUP_Out = levelup_q;
  assign SC_LEVELTICKER_LEVEL_Out   = level_q;
  assign SC_LEVELTICKER_RUNNING_Out = (state_q == ST_RUN);
  assign SC_LEVELTICKER_DONE_Out    = (state_q == ST_DONE);

endmodule

// File: tb/tb_sc_levelticker.sv
// tb/tb_sc_levelticker.sv - directed-vector bench for sc_levelticker
module tb_sc_levelticker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: default parameters
  logic        rst_a = 1'b1, start_a = 1'b1;
  logic [31:0] period_a = 32'd4;
  logic        tick_a, lvup_a, run_a, done_a;
  logic [7:0]  level_a;

  // Instance B: TICKS_PER_LEVEL = 3
  logic        rst_b = 1'b1, start_b = 1'b1;
  logic [31:0] period_b = 32'd4;
  logic        tick_b, lvup_b, run_b, done_b;
  logic [7:0]  level_b;

  // Instance C: MAX_LEVEL = 2, TICKS_PER_LEVEL = 1
  logic        rst_c = 1'b1, start_c = 1'b1;
  logic [31:0] period_c = 32'd2;
  logic        tick_c, lvup_c, run_c, done_c;
  logic [7:0]  level_c;

  sc_levelticker dut_a (
    .SC_LEVELTICKER_CLOCK_50     (clk),
    .SC_LEVELTICKER_RESET_InHigh (rst_a),
    .SC_LEVELTICKER_START_InLow  (start_a),
    .SC_LEVELTICKER_PERIOD_In    (period_a),
    .SC_LEVELTICKER_TICK_Out     (tick_a),
    .SC_LEVELTICKER_LEVELUP_Out  (lvup_a),
    .SC_LEVELTICKER_LEVEL_Out    (level_a),
    .SC_LEVELTICKER_RUNNING_Out  (run_a),
    .SC_LEVELTICKER_DONE_Out     (done_a)
  );

  sc_levelticker #(.TICKS_PER_LEVEL(3)) dut_b (
    .SC_LEVELTICKER_CLOCK_50     (clk),
    .SC_LEVELTICKER_RESET_InHigh (rst_b),
    .SC_LEVELTICKER_START_InLow  (start_b),
    .SC_LEVELTICKER_PERIOD_In    (period_b),
    .SC_LEVELTICKER_TICK_Out     (tick_b),
    .SC_LEVELTICKER_LEVELUP_Out  (lvup_b),
    .SC_LEVELTICKER_LEVEL_Out    (level_b),
    .SC_LEVELTICKER_RUNNING_Out  (run_b),
    .SC_LEVELTICKER_DONE_Out     (done_b)
  );

  sc_levelticker #(.TICKS_PER_LEVEL(1), .MAX_LEVEL(2)) dut_c (
    .SC_LEVELTICKER_CLOCK_50     (clk),
    .SC_LEVELTICKER_RESET_InHigh (rst_c),
    .SC_LEVELTICKER_START_InLow  (start_c),
    .SC_LEVELTICKER_PERIOD_In    (period_c),
    .SC_LEVELTICKER_TICK_Out     (tick_c),
    .SC_LEVELTICKER_LEVELUP_Out  (lvup_c),
    .SC_LEVELTICKER_LEVEL_Out    (level_c),
    .SC_LEVELTICKER_RUNNING_Out  (run_c),
    .SC_LEVELTICKER_DONE_Out     (done_c)
  );

  // Vectors are packed {tick, levelup, running, done, level}
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      got = {tick_a, lvup_a, run_a, done_a, level_a};
      n_vec++;
      if (got !== 12'h000) begin
        n_err++;
        $display("FAIL reset_idle_a k=%0d got=%h exp=%h", k, got, 12'h000);
      end
    end
    got = {tick_b, lvup_b, run_b, done_b, level_b} | {tick_c, lvup_c, run_c, done_c, level_c};
    n_vec++;
    if (got !== 12'h000) begin
      n_err++;
      $display("FAIL reset_idle_bc got=%h exp=%h", got, 12'h000);
    end
  endtask

  task automatic test_period4();
    logic [11:0] got, exp;
    period_a = 32'd4;
    start_a  = 1'b0;
    step();
    start_a = 1'b1;
    got = {tick_a, lvup_a, run_a, done_a, level_a};
    n_vec++;
    if (got !== 12'h200) begin
      n_err++;
      $display("FAIL start_running got=%h exp=%h", got, 12'h200);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {(k % 4 == 0), 1'b0, 1'b1, 1'b0, 8'd0};
      got = {tick_a, lvup_a, run_a, done_a, level_a};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL period4_tick k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_period_change();
    logic exp;
    for (int k = 13; k <= 22; k++) begin
      step();
      if (k == 13) period_a = 32'd6;
      exp = (k == 16) || (k == 22);
      n_vec++;
      if (tick_a !== exp) begin
        n_err++;
        $display("FAIL period_change_tick k=%0d got=%b exp=%b", k, tick_a, exp);
      end
    end
  endtask

  task automatic test_period_zero();
    logic [11:0] got, exp;
    rst_a    = 1'b1;
    period_a = 32'd0;
    step();
    rst_a   = 1'b0;
    start_a = 1'b0;
    step();
    start_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = {1'b1, (k == 8), 1'b1, 1'b0, (k >= 8) ? 8'd1 : 8'd0};
      got = {tick_a, lvup_a, run_a, done_a, level_a};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL period0_every_cycle k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  // P=4, 3 ticks per level; reset lands on the edge of the 11th expiry at LEVEL=3
  task automatic test_levels_and_reset_on_tick();
    logic [11:0] got, exp;
    int          n;
    logic        t;
    rst_b    = 1'b1;
    period_b = 32'd4;
    step();
    rst_b   = 1'b0;
    start_b = 1'b0;
    step();
    start_b = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      step();
      n   = k / 4;
      t   = (k % 4 == 0);
      exp = {t, t && (n % 3 == 0), 1'b1, 1'b0, 8'(n / 3)};
      got = {tick_b, lvup_b, run_b, done_b, level_b};
      if (k % 4 == 0 || k == 43) begin
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL level_count k=%0d got=%h exp=%h", k, got, exp);
        end
      end
    end
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    got = {tick_b, lvup_b, run_b, done_b, level_b};
    n_vec++;
    if (got !== 12'h000) begin
      n_err++;
      $display("FAIL reset_over_tick got=%h exp=%h", got, 12'h000);
    end
    repeat (10) step();
    got = {tick_b, lvup_b, run_b, done_b, level_b};
    n_vec++;
    if (got !== 12'h000) begin
      n_err++;
      $display("FAIL reset_stays_idle got=%h exp=%h", got, 12'h000);
    end
    start_b = 1'b0;
    step();
    start_b = 1'b1;
    got = {tick_b, lvup_b, run_b, done_b, level_b};
    n_vec++;
    if (got !== 12'h200) begin
      n_err++;
      $display("FAIL restart_running got=%h exp=%h", got, 12'h200);
    end
  endtask

  task automatic test_done();
    logic [11:0] got, exp;
    logic        t;
    rst_c    = 1'b1;
    period_c = 32'd2;
    step();
    rst_c   = 1'b0;
    start_c = 1'b0;
    step();
    start_c = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      t = (k == 2) || (k == 4);
      if (k <= 4) begin
        exp = {t, t, 1'b1, 1'b0, (k >= 4) ? 8'd2 : ((k >= 2) ? 8'd1 : 8'd0)};
      end else begin
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
      end
      got = {tick_c, lvup_c, run_c, done_c, level_c};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL done_entry k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    for (int k = 0; k < 50; k++) begin
      start_c = k[0];
      step();
      got = {tick_c, lvup_c, run_c, done_c, level_c};
      n_vec++;
      if (got !== 12'h102) begin
        n_err++;
        $display("FAIL done_hold k=%0d got=%h exp=%h", k, got, 12'h102);
      end
    end
    start_c = 1'b1;
  endtask

  initial begin
    test_reset();
    test_period4();
    test_period_change();
    test_period_zero();
    test_levels_and_reset_on_tick();
    test_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
